// File: rtl/ball_motion_ctrl.sv
// Ball motion sequencer: once per game tick it erases the ball square, resolves
// wall/paddle/floor collisions, steps the ball and redraws it through the plotter.
module ball_motion_ctrl #(
   parameter int          SCREEN_W    = 160,
   parameter int          SCREEN_H    = 120,
   parameter int          BALL_SIZE   = 2,
   parameter int          PADDLE_Y    = 110,
   parameter int          PADDLE_W    = 16,
   parameter int          TICK_DIV    = 833334,
   parameter int          X_START     = 80,
   parameter int          Y_START     = 60,
   parameter logic [2:0]  BALL_COLOUR = 3'b111
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       go,
   input  logic [9:0] paddle_x,
   output logic [9:0] plot_x,
   output logic [9:0] plot_y,
   output logic [2:0] plot_colour,
   output logic       plot_valid,
   input  logic       plot_ready,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic [1:0] dir,
   output logic       miss,
   output logic       busy
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SZ_W  = (BALL_SIZE > 1) ? $clog2(BALL_SIZE) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ERASE  = 2'd1,
      UPDATE = 2'd2,
      DRAW   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SZ_W-1:0]  col_q, col_d, row_q, row_d;
   logic [9:0]       ball_x_q, ball_x_d, ball_y_q, ball_y_d;
   logic [1:0]       dir_q, dir_d;
   logic [9:0]       plot_x_q, plot_x_d, plot_y_q, plot_y_d;
   logic [2:0]       plot_colour_q, plot_colour_d;
   logic             plot_valid_q, plot_valid_d;
   logic             miss_q, miss_d;
   logic             busy_q, busy_d;

   logic             tick;
   logic             accept;
   logic             last_pix;
   logic [SZ_W-1:0]  next_col, next_row;

   logic [10:0]      x_ext, y_ext, px_ext;
   logic             hit_left, hit_right, hit_top, hit_paddle, hit_floor;
   logic             overlap;
   logic [1:0]       new_dir;
   logic [9:0]       step_x, step_y;

   assign tick     = (cnt_q == CNT_W'(TICK_DIV - 1));
   assign accept   = plot_valid_q && plot_ready;
   assign last_pix = (col_q == SZ_W'(BALL_SIZE - 1)) && (row_q == SZ_W'(BALL_SIZE - 1));

   // Row-major walk over the ball square.
   always_comb begin
      next_col = col_q + SZ_W'(1);
      next_row = row_q;
      if (col_q == SZ_W'(BALL_SIZE - 1)) begin
         next_col = '0;
         next_row = row_q + SZ_W'(1);
      end
   end

   // Collision tests use the pre-step position, so the subsequent +/-1 step
   // can never leave the screen or wrap below zero.
   always_comb begin
      x_ext      = {1'b0, ball_x_q};
      y_ext      = {1'b0, ball_y_q};
      px_ext     = {1'b0, paddle_x};
      hit_left   = dir_q[0] && (ball_x_q == 10'd0);
      hit_right  = !dir_q[0] && ((x_ext + 11'(BALL_SIZE)) == 11'(SCREEN_W));
      hit_top    = dir_q[1] && (ball_y_q == 10'd0);
      overlap    = ((x_ext + 11'(BALL_SIZE - 1)) >= px_ext) &&
                   (x_ext <= (px_ext + 11'(PADDLE_W - 1)));
      hit_paddle = !dir_q[1] && ((y_ext + 11'(BALL_SIZE)) == 11'(PADDLE_Y)) && overlap;
      hit_floor  = !dir_q[1] && ((y_ext + 11'(BALL_SIZE)) == 11'(SCREEN_H));
      new_dir    = {dir_q[1] ^ (hit_top | hit_paddle), dir_q[0] ^ (hit_left | hit_right)};
      step_x     = new_dir[0] ? (ball_x_q - 10'd1) : (ball_x_q + 10'd1);
      step_y     = new_dir[1] ? (ball_y_q - 10'd1) : (ball_y_q + 10'd1);
   end

   always_comb begin
      cnt_d         = tick ? '0 : (cnt_q + CNT_W'(1));
      state_d       = state_q;
      col_d         = col_q;
      row_d         = row_q;
      ball_x_d      = ball_x_q;
      ball_y_d      = ball_y_q;
      dir_d         = dir_q;
      plot_x_d      = plot_x_q;
      plot_y_d      = plot_y_q;
      plot_colour_d = plot_colour_q;
      plot_valid_d  = plot_valid_q;
      miss_d        = 1'b0;

      case (state_q)
         IDLE: begin
            if (tick && go) begin
               state_d       = ERASE;
               col_d         = '0;
               row_d         = '0;
               plot_x_d      = ball_x_q;
               plot_y_d      = ball_y_q;
               plot_colour_d = 3'b000;
               plot_valid_d  = 1'b1;
            end
         end
         ERASE, DRAW: begin
            // Coordinates only move on an accepted pixel, so a stalled plotter
            // sees a stable request.
            if (accept) begin
               if (last_pix) begin
                  state_d      = (state_q == ERASE) ? UPDATE : IDLE;
                  plot_valid_d = 1'b0;
               end else begin
                  col_d    = next_col;
                  row_d    = next_row;
                  plot_x_d = ball_x_q + 10'(next_col);
                  plot_y_d = ball_y_q + 10'(next_row);
               end
            end
         end
         UPDATE: begin
            if (hit_floor) begin
               miss_d   = 1'b1;
               ball_x_d = 10'(X_START);
               ball_y_d = 10'(Y_START);
               dir_d    = 2'b00;
            end else begin
               dir_d    = new_dir;
               ball_x_d = step_x;
               ball_y_d = step_y;
            end
            state_d       = DRAW;
            col_d         = '0;
            row_d         = '0;
            plot_x_d      = ball_x_d;
            plot_y_d      = ball_y_d;
            plot_colour_d = BALL_COLOUR;
            plot_valid_d  = 1'b1;
         end
         default: begin
            state_d      = IDLE;
            plot_valid_d = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         col_q         <= '0;
         row_q         <= '0;
         ball_x_q      <= 10'(X_START);
         ball_y_q      <= 10'(Y_START);
         dir_q         <= 2'b00;
         plot_x_q      <= 10'd0;
         plot_y_q      <= 10'd0;
         plot_colour_q <= 3'b000;
         plot_valid_q  <= 1'b0;
         miss_q        <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         col_q         <= col_d;
         row_q         <= row_d;
         ball_x_q      <= ball_x_d;
         ball_y_q      <= ball_y_d;
         dir_q         <= dir_d;
         plot_x_q      <= plot_x_d;
         plot_y_q      <= plot_y_d;
         plot_colour_q <= plot_colour_d;
         plot_valid_q  <= plot_valid_d;
         miss_q        <= miss_d;
         busy_q        <= busy_d;
      end
   end

   assign plot_x      = plot_x_q;
   assign plot_y      = plot_y_q;
   assign plot_colour = plot_colour_q;
   assign plot_valid  = plot_valid_q;
   assign ball_x      = ball_x_q;
   assign ball_y      = ball_y_q;
   assign dir         = dir_q;
   assign miss        = miss_q;
   assign busy        = busy_q;

   stall_hold_a : assert property (@(posedge clk) disable iff (!resetn)
      (plot_valid && !plot_ready) |=>
         (plot_valid && $stable(plot_x) && $stable(plot_y) && $stable(plot_colour)));

   miss_pulse_a : assert property (@(posedge clk) disable iff (!resetn)
      miss |=> !miss);

endmodule
